ysyx_22040632_clint_mh: RTL
===========================

Name: ysyx_22040632_clint_mh

Overview:
Multi-hart core-local interruptor; successor to the single-hart timer block. Provides one shared 64-bit mtime with a programmable prescaler, and per-hart mtimecmp and msip registers. Hart interrupts are level outputs (mtip/msip) to each hart's CSR unit; mie gating stays in the CSR unit. Accessed over a 32-bit register bus from the LSU/MMIO path with single-cycle registered read latency.

Parameters:
NUM_HARTS, 2, number of harts (1..16); sizes the mtimecmp/msip arrays and the irq vectors.
TICK_DIV, 1, mtime increments once every TICK_DIV clk cycles (1..255); 1 = every cycle.
BASE_ADDR, 32'h0200_0000, region base; msip[h] @ +4*h, mtimecmp[h] lo/hi @ +0x4000+8*h / +4, mtime lo/hi @ +0xBFF8 / +0xBFFC.

Ports:
clk  in  1  system clock
rrst  in  1  synchronous reset, active-high
req_valid  in  1  bus request valid
req_ready  out  1  always 1 (accepts every cycle)
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte enables (writes only)
rsp_valid  out  1  response valid, exactly 1 cycle after an accepted request
rsp_rdata  out  32  read data (0 for writes/errors)
rsp_err  out  1  unmapped or misaligned access
mtip  out  NUM_HARTS  per-hart timer interrupt pending
msip  out  NUM_HARTS  per-hart software interrupt pending

Behaviour:
- Reset (rrst=1 at posedge): mtime=0, prescaler=0, all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip regs=0, mtip=0, msip=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset during an outstanding request drops the response.
- Prescaler: counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1); wraps to 0 on tick. TICK_DIV=1 gives a tick every cycle.
- mtime: +1 on tick, wraps 64'hFFFF..FF -> 0. A bus write to either mtime half takes priority over the tick in that cycle; the other half keeps its current (unincremented) value. The prescaler is not reset by mtime writes.
- Writes: byte-merged per req_wstrb into the addressed 32-bit half; result is visible to reads issued the next cycle. msip registers: only bit 0 is stored; other bits read 0.
- Reads: rsp_rdata = register value sampled in the accept cycle (the pre-write value if the same register is being written — impossible, since there is one request per cycle).
- Errors: addr[1:0]!=0, an address outside the map, or hart index >= NUM_HARTS -> rsp_err=1, rsp_rdata=0, no state change; rsp_valid still asserts.
- mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]) using current register values, so it lags a register update by 1 cycle. The comparison is unsigned 64-bit, with no sticky state; writing mtimecmp above mtime clears mtip on the cycle after the write lands.
- msip[h] = registered copy of msip register bit 0, with the same 1-cycle lag.
- No state machine beyond the response pipeline register: IDLE (rsp_valid=0) / RESP (rsp_valid=1); a back-to-back request keeps it in RESP.

Optional Feature:
Macro: YSYX_22040632_CLINT_DBG_HALT_EN. When defined, adds input dbg_halt (1 bit, sized NUM_HARTS-agnostic). While dbg_halt=1, the prescaler and mtime hold; bus writes to mtime still apply, and mtip evaluation continues. When the macro is undefined, the port is absent and mtime always runs.

Decomposition:
- Package ysyx_22040632_riscv_pkg: CLINT offset constants (MSIP_OFF=0x0, MTIMECMP_OFF=0x4000, MTIME_OFF=0xBFF8), a clint_req_t struct (we, addr, wdata, wstrb), and a clint_rsp_t struct (rdata, err).
- Sub-module ysyx_22040632_clint_tick: prescaler plus 64-bit mtime counter, with write-override and halt inputs.
- The top level holds address decode, per-hart register arrays, compare, and the response register.

Test Plan:
- Reset, then read mtimecmp[0] lo/hi -> 0xFFFFFFFF/0xFFFFFFFF, rsp_err=0; mtip=0 for 1000 cycles.
- TICK_DIV=4: release reset, read mtime lo at cycle 40 -> 10 (±1 per documented sampling).
- Write mtimecmp[1]={0,20} with mtime=0, TICK_DIV=1 -> mtip[1] rises the cycle after mtime reaches 20, mtip[0] stays 0; then write mtimecmp[1] lo=0xFFFFFFFF -> mtip[1] falls 2 cycles later.
- Write mtime lo=0xFFFFFFFF, hi=0 -> one tick later read hi=1, lo=0 (carry); a write in the same cycle as a tick stores the written value exactly.
- Write msip[1] wdata=0xFFFF_FFFF, wstrb=4'b0001 -> msip[1]=1 next cycle, read returns 0x1; wstrb=4'b0010 with wdata=0 -> msip remains 1.
- Read addr BASE+0x4002 (misaligned) and BASE+8 with NUM_HARTS=2 -> rsp_valid=1, rsp_err=1, rdata=0, with no register change.

Source files
------------

// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared CLINT definitions: register-map offsets, bus bundles, byte-merge helper.
// Optional debug halt of mtime is enabled by defining YSYX_22040632_CLINT_DBG_HALT_EN.
package ysyx_22040632_riscv_pkg;

    localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
    localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } clint_rsp_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22040632_clint_tick.sv
// Shared timebase: prescaler plus 64-bit mtime with per-half bus write override.
// A halted timebase still accepts bus writes to mtime.
module ysyx_22040632_clint_tick
    import ysyx_22040632_riscv_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rrst,
    input  logic        halt,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);

    localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

    logic [7:0] presc;
    logic       tick;

    assign tick = (presc == LAST);

    always_ff @(posedge clk) begin
        if (rrst) begin
            presc <= '0;
        end else if (!halt) begin
            presc <= tick ? 8'd0 : presc + 8'd1;
        end
    end

    // A write to one half freezes the other half at its unincremented value.
    always_ff @(posedge clk) begin
        if (rrst) begin
            mtime <= '0;
        end else if (wr_lo || wr_hi) begin
            mtime <= {wr_hi ? merge_bytes(mtime[63:32], wdata, wstrb) : mtime[63:32],
                      wr_lo ? merge_bytes(mtime[31:0], wdata, wstrb) : mtime[31:0]};
        end else if (tick && !halt) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/ysyx_22040632_clint_mh.sv
// Multi-hart CLINT: address decode, per-hart msip/mtimecmp, compare, response register.
// Define YSYX_22040632_CLINT_DBG_HALT_EN to add the dbg_halt input that freezes mtime.
module ysyx_22040632_clint_mh
    import ysyx_22040632_riscv_pkg::*;
#(
    parameter int          NUM_HARTS = 2,
    parameter int          TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic                 clk,
    input  logic                 rrst,
`ifdef YSYX_22040632_CLINT_DBG_HALT_EN
    input  logic                 dbg_halt,
`endif
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

    clint_req_t            req;
    clint_rsp_t            rsp_q;
    logic                  state;
    logic [31:0]           off;
    logic                  aligned, hit_sw, hit_cmp, hit_time, hi, err, wr;
    logic [3:0]            sw_idx, cmp_idx;
    logic [31:0]           rd;
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0]  sw;
    logic                  halt;

`ifdef YSYX_22040632_CLINT_DBG_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
    assign req_ready = 1'b1;

    // Offsets below BASE_ADDR wrap to huge values and fall out of every window.
    assign off      = req.addr - BASE_ADDR;
    assign aligned  = (off[1:0] == 2'b00);
    assign hit_sw   = aligned && (off < MSIP_OFF + 32'(4 * NUM_HARTS));
    assign hit_cmp  = aligned && (off >= MTIMECMP_OFF)
                   && (off < MTIMECMP_OFF + 32'(8 * NUM_HARTS));
    assign hit_time = aligned && ((off == MTIME_OFF) || (off == MTIME_OFF + 32'd4));
    assign err      = !(hit_sw || hit_cmp || hit_time);
    assign wr       = req_valid && req.we && !err;
    assign hi       = off[2];
    assign sw_idx   = off[5:2];
    assign cmp_idx  = off[6:3];

    always_comb begin
        rd = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (hit_sw && sw_idx == 4'(h)) rd = {31'b0, sw[h]};
            if (hit_cmp && cmp_idx == 4'(h)) rd = hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
        if (hit_time) rd = hi ? mtime[63:32] : mtime[31:0];
    end

    ysyx_22040632_clint_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rrst  (rrst),
        .halt  (halt),
        .wr_lo (wr && hit_time && !hi),
        .wr_hi (wr && hit_time && hi),
        .wdata (req.wdata),
        .wstrb (req.wstrb),
        .mtime (mtime)
    );

    always_ff @(posedge clk) begin
        if (rrst) begin
            sw <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr && hit_sw && sw_idx == 4'(h) && req.wstrb[0]) sw[h] <= req.wdata[0];
                if (wr && hit_cmp && cmp_idx == 4'(h)) begin
                    if (hi) mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], req.wdata, req.wstrb);
                    else    mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], req.wdata, req.wstrb);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rrst) begin
            mtip <= '0;
            msip <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
            msip <= sw;
        end
    end

    always_ff @(posedge clk) begin
        if (rrst) begin
            state <= ST_IDLE;
            rsp_q <= '0;
        end else begin
            state       <= req_valid ? ST_RESP : ST_IDLE;
            rsp_q.rdata <= (req_valid && !req.we && !err) ? rd : 32'd0;
            rsp_q.err   <= req_valid && err;
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule
